// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_pkg
// Description : Shared definitions for the Brainfuck execution core.
//               Contents:
//                 - ASCII opcode byte constants
//                 - core state enum
//                 - bracket-scan direction enum
//                 - helper that flags opcodes needing a data read
// Revision    : 1.0 - initial release
// ============================================================================
package bf_pkg;

  localparam logic [7:0] OP_INC_DP = 8'h3E;  // '>'
  localparam logic [7:0] OP_DEC_DP = 8'h3C;  // '<'
  localparam logic [7:0] OP_INC    = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC    = 8'h2D;  // '-'
  localparam logic [7:0] OP_OUT    = 8'h2E;  // '.'
  localparam logic [7:0] OP_JZ     = 8'h5B;  // '['
  localparam logic [7:0] OP_JNZ    = 8'h5D;  // ']'
  localparam logic [7:0] OP_END    = 8'h00;  // program terminator

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXEC       = 3'd2,
    ST_SCAN_FETCH = 3'd3,
    ST_SCAN_CHECK = 3'd4,
    ST_HALT       = 3'd5
  } state_t;

  typedef enum logic {
    DIR_FWD  = 1'b0,
    DIR_BACK = 1'b1
  } dir_t;

  // Opcodes whose execution depends on the current data cell.
  function automatic logic needs_data(input logic [7:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_OUT) ||
           (op == OP_JZ)  || (op == OP_JNZ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf_proc_core.sv
`default_nettype none
// ============================================================================
// Module      : bf_proc_core
// Description : Brainfuck execution core. Fetches ASCII instructions from an
//               external synchronous ROM and operates on an external
//               synchronous RAM. Both memories have one cycle of read latency.
// Ports       :
//   clk        - clock
//   rstn       - asynchronous active-low reset
//   en         - clock enable; low freezes everything and masks strobes
//   prog_addr  - ROM address (program counter)
//   prog_ren   - ROM read strobe, data on prog_rval the following cycle
//   prog_rval  - ROM read data
//   data_addr  - RAM address (data pointer), shared read/write
//   data_ren   - RAM read strobe, data on data_rval the following cycle
//   data_wen   - RAM write strobe
//   data_wval  - RAM write data
//   data_rval  - RAM read data
//   stdout     - last output byte, held until the next '.'
//   stdout_en  - one-cycle pulse per '.'
// Revision    : 1.0 - initial release
// ============================================================================
module bf_proc_core
  import bf_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH  = 16,
  parameter int DATA_VALUE_WIDTH = 32,
  parameter int PROG_ADDR_WIDTH  = 16,
  parameter int PROG_VALUE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  output logic [PROG_ADDR_WIDTH-1:0]  prog_addr,
  output logic                        prog_ren,
  input  logic [PROG_VALUE_WIDTH-1:0] prog_rval,
  output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
  output logic                        data_ren,
  output logic                        data_wen,
  output logic [DATA_VALUE_WIDTH-1:0] data_wval,
  input  logic [DATA_VALUE_WIDTH-1:0] data_rval,
  output logic [7:0]                  stdout,
  output logic                        stdout_en
);

  localparam logic [PROG_ADDR_WIDTH-1:0] c_pc_one    = PROG_ADDR_WIDTH'(1);
  localparam logic [PROG_ADDR_WIDTH-1:0] c_pc_zero   = '0;
  localparam logic [DATA_ADDR_WIDTH-1:0] c_dp_one    = DATA_ADDR_WIDTH'(1);
  localparam logic [DATA_VALUE_WIDTH-1:0] c_val_one  = DATA_VALUE_WIDTH'(1);

  state_t                       r_state;
  dir_t                         r_dir;
  logic [PROG_ADDR_WIDTH-1:0]   r_pc;
  logic [DATA_ADDR_WIDTH-1:0]   r_dp;
  logic [PROG_ADDR_WIDTH-1:0]   r_depth;
  logic [7:0]                   r_instr;
  logic [7:0]                   r_stdout;
  logic                         r_stdout_en;

  logic [7:0] w_op;
  logic       w_live;
  logic       w_opens;
  logic       w_closes;

  assign w_op = prog_rval[7:0];

  // Strobes are decoded from state and masked by enable and reset so that a
  // frozen or resetting core never touches either memory.
  assign w_live = en && rstn;

  // During a scan, "opening" means a bracket that nests deeper in the
  // current direction of travel.
  assign w_opens  = (r_dir == DIR_FWD) ? (w_op == OP_JZ)  : (w_op == OP_JNZ);
  assign w_closes = (r_dir == DIR_FWD) ? (w_op == OP_JNZ) : (w_op == OP_JZ);

  assign prog_addr = r_pc;
  assign prog_ren  = w_live && ((r_state == ST_FETCH) || (r_state == ST_SCAN_FETCH));
  assign data_addr = r_dp;
  assign data_ren  = w_live && (r_state == ST_DECODE) && needs_data(w_op);
  assign data_wen  = w_live && (r_state == ST_EXEC) &&
                     ((r_instr == OP_INC) || (r_instr == OP_DEC));
  assign data_wval = (r_instr == OP_DEC) ? (data_rval - c_val_one)
                                         : (data_rval + c_val_one);
  assign stdout    = r_stdout;
  assign stdout_en = r_stdout_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_FETCH;
      r_dir       <= DIR_FWD;
      r_pc        <= '0;
      r_dp        <= '0;
      r_depth     <= '0;
      r_instr     <= '0;
      r_stdout    <= '0;
      r_stdout_en <= 1'b0;
    end else if (en) begin
      r_stdout_en <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          r_instr <= w_op;
          if (w_op == OP_END) begin
            r_state <= ST_HALT;
          end else if (needs_data(w_op)) begin
            r_state <= ST_EXEC;
          end else begin
            if (w_op == OP_INC_DP) r_dp <= r_dp + c_dp_one;
            if (w_op == OP_DEC_DP) r_dp <= r_dp - c_dp_one;
            r_pc    <= r_pc + c_pc_one;
            r_state <= ST_FETCH;
          end
        end

        ST_EXEC: begin
          r_pc    <= r_pc + c_pc_one;
          r_state <= ST_FETCH;
          case (r_instr)
            OP_OUT: begin
              r_stdout    <= data_rval[7:0];
              r_stdout_en <= 1'b1;
            end
            OP_JZ: begin
              if (data_rval == '0) begin
                r_depth <= c_pc_one;
                r_dir   <= DIR_FWD;
                r_state <= ST_SCAN_FETCH;
              end
            end
            OP_JNZ: begin
              if (data_rval != '0) begin
                r_depth <= c_pc_one;
                r_dir   <= DIR_BACK;
                r_pc    <= r_pc - c_pc_one;
                r_state <= ST_SCAN_FETCH;
              end
            end
            default: ;
          endcase
        end

        ST_SCAN_FETCH: begin
          r_state <= ST_SCAN_CHECK;
        end

        ST_SCAN_CHECK: begin
          if ((r_dir == DIR_FWD) && (w_op == OP_END)) begin
            r_state <= ST_HALT;
          end else if (w_closes && (r_depth == c_pc_one)) begin
            // Matching bracket found: resume just past it in either direction.
            r_depth <= '0;
            r_pc    <= r_pc + c_pc_one;
            r_state <= ST_FETCH;
          end else begin
            if (w_opens)       r_depth <= r_depth + c_pc_one;
            else if (w_closes) r_depth <= r_depth - c_pc_one;
            if ((r_dir == DIR_BACK) && (r_pc == c_pc_zero)) begin
              r_state <= ST_HALT;
            end else begin
              r_pc    <= (r_dir == DIR_FWD) ? (r_pc + c_pc_one) : (r_pc - c_pc_one);
              r_state <= ST_SCAN_FETCH;
            end
          end
        end

        ST_HALT: begin
          r_state <= ST_HALT;
        end

        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf_proc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf_proc_core
// Description : Directed self-checking bench for bf_proc_core with small
//               behavioural ROM/RAM models (one-cycle registered reads).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf_proc_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] prog_addr;
  logic        prog_ren;
  logic [7:0]  prog_rval = 8'h00;
  logic [15:0] data_addr;
  logic        data_ren;
  logic        data_wen;
  logic [31:0] data_wval;
  logic [31:0] data_rval = 32'h0;
  logic [7:0]  stdout;
  logic        stdout_en;

  bf_proc_core dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .prog_addr (prog_addr),
    .prog_ren  (prog_ren),
    .prog_rval (prog_rval),
    .data_addr (data_addr),
    .data_ren  (data_ren),
    .data_wen  (data_wen),
    .data_wval (data_wval),
    .data_rval (data_rval),
    .stdout    (stdout),
    .stdout_en (stdout_en)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [0:255];
  logic [31:0] ram [0:15];
  logic        clear_ram = 1'b0;

  always @(posedge clk) begin
    if (prog_ren) prog_rval <= rom[prog_addr[7:0]];
    if (clear_ram) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
    end else begin
      if (data_ren) data_rval <= ram[data_addr[3:0]];
      if (data_wen) ram[data_addr[3:0]] <= data_wval;
    end
  end

  // Running event counters; the directed sequence works with differences.
  int pulses = 0;
  int writes = 0;
  int frozen_act = 0;
  int both_strobes = 0;

  always @(negedge clk) begin
    if (stdout_en) pulses++;
    if (data_wen) writes++;
    if (!en && (prog_ren || data_ren || data_wen)) frozen_act++;
    if (data_ren && data_wen) both_strobes++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input string s);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  // Hold reset, clear RAM, load ROM, then release with enable high.
  task automatic start_prog(input string s);
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    load_prog(s);
    clear_ram = 1'b1;
    @(negedge clk);
    clear_ram = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    en   = 1'b1;
  endtask

  // Halt is recognised as a long run with no ROM fetches.
  task automatic run_to_halt(input string tag);
    int idle = 0;
    int n = 0;
    while (idle < 8 && n < 3000) begin
      @(negedge clk);
      n++;
      if (prog_ren) idle = 0;
      else idle++;
    end
    check(tag, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_pulses(input string tag, input int target);
    int n = 0;
    while (pulses < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, (pulses >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int p0, w0, fa0, cnt;

    // ---------------- reset state ----------------
    load_prog("+++.");
    @(negedge clk);
    check("rst_prog_ren", {31'd0, prog_ren}, 32'd0);
    check("rst_data_ren", {31'd0, data_ren}, 32'd0);
    check("rst_data_wen", {31'd0, data_wen}, 32'd0);
    check("rst_stdout", {24'd0, stdout}, 32'd0);
    check("rst_stdout_en", {31'd0, stdout_en}, 32'd0);

    // ---------------- "+++." ----------------
    start_prog("+++.");
    p0 = pulses; w0 = writes;
    #1;
    check("t1_first_fetch_ren", {31'd0, prog_ren}, 32'd1);
    check("t1_first_fetch_addr", {16'd0, prog_addr}, 32'd0);
    run_to_halt("t1_halt_timeout");
    check("t1_pulses", pulses - p0, 32'd1);
    check("t1_stdout", {24'd0, stdout}, 32'h03);
    check("t1_writes", writes - w0, 32'd3);
    check("t1_ram0", ram[0], 32'd3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prog_ren) cnt++;
    end
    check("t1_halt_no_fetch", cnt, 32'd0);

    // ---------------- ">+<-" ----------------
    start_prog(">+<-");
    p0 = pulses;
    run_to_halt("t2_halt_timeout");
    check("t2_ram1", ram[1], 32'd1);
    check("t2_ram0_wrap", ram[0], 32'hFFFF_FFFF);
    check("t2_dp_final", {16'd0, data_addr}, 32'd0);
    check("t2_no_pulses", pulses - p0, 32'd0);

    // ---------------- "++[->+<]>." ----------------
    start_prog("++[->+<]>.");
    p0 = pulses;
    run_to_halt("t3_halt_timeout");
    check("t3_pulses", pulses - p0, 32'd1);
    check("t3_stdout", {24'd0, stdout}, 32'h02);
    check("t3_ram0", ram[0], 32'd0);
    check("t3_ram1", ram[1], 32'd2);

    // ---------------- "[+[+]]+." nested forward skip ----------------
    start_prog("[+[+]]+.");
    p0 = pulses; w0 = writes;
    run_to_halt("t4_halt_timeout");
    check("t4_pulses", pulses - p0, 32'd1);
    check("t4_stdout", {24'd0, stdout}, 32'h01);
    check("t4_writes", writes - w0, 32'd1);
    check("t4_ram0", ram[0], 32'd1);

    // ---------------- "+.+." with enable held low ----------------
    start_prog("+.+.");
    p0 = pulses; fa0 = frozen_act;
    wait_pulses("t5_first_pulse_timeout", p0 + 1);
    check("t5_first_stdout", {24'd0, stdout}, 32'h01);
    @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stdout !== 8'h01 || stdout_en !== 1'b0) cnt = -1;
    end
    check("t5_frozen_activity", frozen_act - fa0, 32'd0);
    check("t5_frozen_pulses", pulses - p0, 32'd1);
    check("t5_hold_stdout", {24'd0, stdout}, 32'h01);
    check("t5_hold_stdout_en", {31'd0, stdout_en}, 32'd0);
    en = 1'b1;
    run_to_halt("t5_halt_timeout");
    check("t5_pulses", pulses - p0, 32'd2);
    check("t5_stdout", {24'd0, stdout}, 32'h02);
    check("t5_ram0", ram[0], 32'd2);

    // ---------------- async reset mid-scan ----------------
    start_prog("+.-[+[+]]+.");
    p0 = pulses;
    wait_pulses("t6_pulse_timeout", p0 + 1);
    for (int i = 0; i < 9; i++) @(negedge clk);
    check("t6_pre_reset_stdout", {24'd0, stdout}, 32'h01);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_prog_ren", {31'd0, prog_ren}, 32'd0);
    check("t6_async_data_ren", {31'd0, data_ren}, 32'd0);
    check("t6_async_stdout", {24'd0, stdout}, 32'd0);
    check("t6_async_stdout_en", {31'd0, stdout_en}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t6_restart_ren", {31'd0, prog_ren}, 32'd1);
    check("t6_restart_addr", {16'd0, prog_addr}, 32'd0);
    p0 = pulses;
    run_to_halt("t6_halt_timeout");
    check("t6_pulses", pulses - p0, 32'd2);
    check("t6_stdout", {24'd0, stdout}, 32'h01);
    check("t6_ram0", ram[0], 32'd1);

    check("never_ren_and_wen", both_strobes, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
